// File: rtl/s1s2_pkg.sv
// Shared S1/S2 serial link definitions.
// Packet = {addr[2:0], data[17:0]}, sent MSB first.
package s1s2_pkg;
  localparam int N_WORDS  = 18;
  localparam int N_PKT    = 8;
  localparam int PKT_AW   = 3;
  localparam int PKT_BITS = PKT_AW + N_WORDS;
  localparam int RB1_AW   = 5;

  typedef enum logic [1:0] {
    LOAD,
    SEND,
    GAP,
    DONE
  } state_e;

  typedef logic [N_WORDS-1:0][N_PKT-1:0] store_t;

  function automatic logic [PKT_BITS-1:0] build_pkt(
    input logic [PKT_AW-1:0] p,
    input store_t            w
  );
    logic [N_WORDS-1:0] d;
    for (int k = 0; k < N_WORDS; k++) begin
      d[k] = w[k][p];
    end
    return {p, d};
  endfunction
endpackage

// File: rtl/s1_shift_out.sv
// Frame shifter: loads a packet, drives sen/sd MSB first.
// last_bit_o pulses in the cycle whose edge drives bit 0.
module s1_shift_out
  import s1s2_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [PKT_BITS-1:0] frame_i,
  output logic                sen_o,
  output logic                sd_o,
  output logic                busy_o,
  output logic                last_bit_o
);
  logic [PKT_BITS-1:0] sh_q;
  logic [4:0]          bit_q;
  logic                busy_q;
  logic                sen_q;
  logic                sd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bit_q  <= '0;
      busy_q <= 1'b0;
      sen_q  <= 1'b1;
      sd_q   <= 1'b0;
    end else if (start_i) begin
      sh_q   <= frame_i;
      bit_q  <= 5'(PKT_BITS - 1);
      busy_q <= 1'b1;
      sen_q  <= 1'b0;
      sd_q   <= frame_i[PKT_BITS-1];
    end else if (busy_q && bit_q != 5'd0) begin
      bit_q <= bit_q - 5'd1;
      sd_q  <= sh_q[bit_q - 5'd1];
    end else if (busy_q) begin
      busy_q <= 1'b0;
      sen_q  <= 1'b1;
      sd_q   <= 1'b0;
    end
  end

  assign sen_o      = sen_q;
  assign sd_o       = sd_q;
  assign busy_o     = busy_q;
  assign last_bit_o = busy_q && bit_q == 5'd1;
endmodule

// File: rtl/s1_serial_tx.sv
// S1 transmit side: loads RB1, sends 8 transposed packets.
// Optional tx_cnt output under macro S1_TX_COUNT_EN.
module s1_serial_tx
  import s1s2_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              RB1_RW,
  output logic [RB1_AW-1:0] RB1_A,
  output logic [N_PKT-1:0]  RB1_D,
  input  logic [N_PKT-1:0]  RB1_Q,
  output logic              sen,
  output logic              sd,
  output logic              S1_done
`ifdef S1_TX_COUNT_EN
  ,
  output logic [3:0]        tx_cnt
`endif
);
  state_e            state_q, state_d;
  logic [RB1_AW-1:0] a_q;
  store_t            words_q;
  logic [3:0]        pkt_q;
  logic [7:0]        gap_q;
  logic              done_q;
  logic              lb_q;
  logic              busy;
  logic              pre_last;
  logic              gap_last;
  logic              start;
  logic [PKT_BITS-1:0] frame;

  assign gap_last = gap_q == 8'(GAP_CYCLES - 1);
  assign start    = (state_q == SEND && !busy) ||
                    (state_q == GAP && gap_last);
  assign frame    = build_pkt(pkt_q[PKT_AW-1:0], words_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD: if (a_q == RB1_AW'(N_WORDS - 1)) state_d = SEND;
      SEND: if (lb_q)
              state_d = (pkt_q == 4'(N_PKT - 1)) ? DONE : GAP;
      GAP:  if (gap_last) state_d = SEND;
      DONE: state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      a_q     <= '0;
      words_q <= '0;
      pkt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lb_q    <= pre_last;
      if (state_q == LOAD) begin
        words_q[a_q] <= RB1_Q;
        if (a_q != RB1_AW'(N_WORDS - 1)) a_q <= a_q + 1'b1;
      end
      if (state_q == SEND && lb_q) begin
        pkt_q <= pkt_q + 4'd1;
        if (pkt_q == 4'(N_PKT - 1)) done_q <= 1'b1;
      end
      if (state_q == GAP) gap_q <= gap_last ? 8'd0 : gap_q + 8'd1;
    end
  end

`ifdef S1_TX_COUNT_EN
  logic [3:0] tx_q;
  always_ff @(posedge clk) begin
    if (rst) tx_q <= '0;
    else if (pre_last && tx_q != 4'(N_PKT)) tx_q <= tx_q + 4'd1;
  end
  assign tx_cnt = tx_q;
`endif

  s1_shift_out u_shift (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .frame_i    (frame),
    .sen_o      (sen),
    .sd_o       (sd),
    .busy_o     (busy),
    .last_bit_o (pre_last)
  );

  assign RB1_RW  = 1'b1;
  assign RB1_D   = '0;
  assign RB1_A   = a_q;
  assign S1_done = done_q;
endmodule

// File: tb/tb_s1_serial_tx.sv
// Bench for s1_serial_tx against a per-edge stream model.
// Build with +define+S1_TX_COUNT_EN to also check tx_cnt.
module tb_s1_serial_tx;
  localparam int NE = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q;
  logic       sen;
  logic       sd;
  logic       S1_done;
`ifdef S1_TX_COUNT_EN
  logic [3:0] tx_cnt;
`endif

  logic [7:0]  mem [18];
  logic [20:0] exp_pkt [8];
  logic        sen_h [NE+1];
  logic        sd_h  [NE+1];
  logic        dn_h  [NE+1];
  logic [4:0]  a_h   [NE+1];
  logic [3:0]  cnt_h [NE+1];

  int total  = 0;
  int passed = 0;

  assign RB1_Q = (RB1_A < 5'd18) ? mem[RB1_A] : 8'h00;

  always #5 clk = ~clk;

  s1_serial_tx dut (
    .clk     (clk),
    .rst     (rst),
    .RB1_RW  (RB1_RW),
    .RB1_A   (RB1_A),
    .RB1_D   (RB1_D),
    .RB1_Q   (RB1_Q),
    .sen     (sen),
    .sd      (sd),
    .S1_done (S1_done)
`ifdef S1_TX_COUNT_EN
    ,
    .tx_cnt  (tx_cnt)
`endif
  );

  task automatic chk(input string tag, input int e,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s edge=%0d obs=%0h exp=%0h",
                tag, e, obs, exp);
  endtask

  task automatic build_model();
    for (int p = 0; p < 8; p++) begin
      logic [2:0] pa;
      pa = 3'(p);
      exp_pkt[p][20:18] = pa;
      for (int k = 0; k < 18; k++) begin
        exp_pkt[p][k] = mem[k][p];
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sen", 0, 32'(sen), 1);
    chk("rst_sd", 0, 32'(sd), 0);
    chk("rst_a", 0, 32'(RB1_A), 0);
    chk("rst_done", 0, 32'(S1_done), 0);
`ifdef S1_TX_COUNT_EN
    chk("rst_cnt", 0, 32'(tx_cnt), 0);
`endif
    rst = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      @(negedge clk);
      sen_h[e] = sen;
      sd_h[e]  = sd;
      dn_h[e]  = S1_done;
      a_h[e]   = RB1_A;
`ifdef S1_TX_COUNT_EN
      cnt_h[e] = tx_cnt;
`else
      cnt_h[e] = 4'd0;
`endif
      if (RB1_RW !== 1'b1 || RB1_D !== 8'h00)
        chk("rw_d", e, {RB1_RW, RB1_D}, 32'h100);
    end
  endtask

  task automatic check_run(input string tag, input int n);
    logic [20:0] rx;
    int          nrx;
    int          bits;
    nrx  = 0;
    bits = 0;
    rx   = '0;
    for (int e = 1; e <= n; e++) begin
      int  t, p, j, cnt;
      logic es, ed;
      es = 1'b1;
      ed = 1'b0;
      t  = e - 19;
      if (t >= 0) begin
        p = t / 22;
        j = t % 22;
        if (p < 8 && j < 21) begin
          es = 1'b0;
          ed = exp_pkt[p][20-j];
        end
      end
      chk({tag, "_sen"}, e, 32'(sen_h[e]), 32'(es));
      chk({tag, "_sd"}, e, 32'(sd_h[e]), 32'(ed));
      chk({tag, "_a"}, e, 32'(a_h[e]), (e < 17) ? e : 17);
      chk({tag, "_done"}, e, 32'(dn_h[e]), (e >= 194) ? 1 : 0);
`ifdef S1_TX_COUNT_EN
      cnt = 0;
      for (int q = 0; q < 8; q++) if (39 + 22 * q <= e) cnt++;
      chk({tag, "_cnt"}, e, 32'(cnt_h[e]), cnt);
`else
      cnt = 0;
`endif
      // receiver view: collect sd while sen is low
      if (sen_h[e] === 1'b0) begin
        rx = {rx[19:0], sd_h[e]};
        bits++;
      end else if (bits != 0) begin
        chk({tag, "_rxlen"}, e, bits, 21);
        if (nrx < 8) chk({tag, "_rxpkt"}, e, 32'(rx), 32'(exp_pkt[nrx]));
        nrx++;
        bits = 0;
      end
    end
    if (n == NE) chk({tag, "_npkt"}, n, nrx, 8);
  endtask

  task automatic run_full(input string tag);
    build_model();
    do_reset();
    capture(NE);
    check_run(tag, NE);
  endtask

  initial begin
    for (int i = 0; i < 18; i++) mem[i] = 8'hFF;
    run_full("allff");

    for (int i = 0; i < 18; i++) mem[i] = 8'h00;
    mem[0] = 8'h01;
    run_full("w0");

    mem[0]  = 8'h00;
    mem[17] = 8'h80;
    run_full("w17");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 18; i++) mem[i] = 8'($urandom);
      run_full("rand");
    end

    for (int i = 0; i < 18; i++) mem[i] = 8'($urandom);
    build_model();
    do_reset();
    capture(59);
    check_run("pre", 59);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_sen", 60, 32'(sen), 1);
    chk("mid_sd", 60, 32'(sd), 0);
    chk("mid_done", 60, 32'(S1_done), 0);
    chk("mid_a", 60, 32'(RB1_A), 0);
    rst = 1'b0;
    capture(NE);
    check_run("restart", NE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
